gray_counter: RTL and testbench

//   Parametrised synchronous up/down counter that keeps a binary count and its

---
 rtl/gray_counter.sv | 72 +++++++
 tb/tb_gray_counter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
// Module      : gray_counter
// Description : Up/down binary counter with a registered Gray-code twin,
//               parallel load and a one-cycle wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_ones      = '1;
    localparam logic [WIDTH-1:0] c_zero      = '0;
    localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_init_gray = INIT ^ (INIT >> 1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH-1:0] w_next_gray;
    logic             w_next_wrap;

    always_comb begin
        w_next_bin  = r_bin;
        w_next_wrap = 1'b0;
        if (load) begin
            w_next_bin = load_bin;
        end else if (en) begin
            if (up) begin
                w_next_bin  = r_bin + c_one;
                w_next_wrap = (r_bin == c_ones);
            end else begin
                w_next_bin  = r_bin - c_one;
                w_next_wrap = (r_bin == c_zero);
            end
        end
    end

    // Gray is derived from the same next-state value so it never lags bin.
    assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= INIT;
            r_gray <= c_init_gray;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_next_bin;
            r_gray <= w_next_gray;
            r_wrap <= w_next_wrap;
        end
    end

    assign bin  = r_bin;
    assign gray = r_gray;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_counter
// Description : Scoreboard bench for gray_counter (WIDTH=4/INIT=0, WIDTH=8/INIT=80).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_counter;

    typedef struct {
        logic [7:0] bin;
        logic [7:0] gray;
        logic       wrap;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit instance
    logic       rst4, en4, up4, load4;
    logic [3:0] load_bin4, bin4, gray4;
    logic       wrap4;

    // 8-bit instance
    logic       rst8, en8, up8, load8;
    logic [7:0] load_bin8, bin8, gray8;
    logic       wrap8;

    gray_counter #(.WIDTH(4), .INIT(4'h0)) u_dut4 (
        .clk(clk), .rst(rst4), .en(en4), .up(up4), .load(load4),
        .load_bin(load_bin4), .bin(bin4), .gray(gray4), .wrap(wrap4)
    );

    gray_counter #(.WIDTH(8), .INIT(8'h80)) u_dut8 (
        .clk(clk), .rst(rst8), .en(en8), .up(up8), .load(load8),
        .load_bin(load_bin8), .bin(bin8), .gray(gray8), .wrap(wrap8)
    );

    exp_t sb4[$];
    exp_t sb8[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [3:0] g_tab [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    task automatic drive4(input logic r, input logic l, input logic [3:0] lb,
                          input logic e, input logic u);
        rst4 = r; load4 = l; load_bin4 = lb; en4 = e; up4 = u;
    endtask

    task automatic push4(input logic [3:0] b, input logic [3:0] g, input logic w);
        exp_t x;
        x.bin = {4'h0, b}; x.gray = {4'h0, g}; x.wrap = w;
        sb4.push_back(x);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        drive4(1'b1, 1'b1, 4'h7, 1'b1, 1'b1);
        rst8 = 1'b1; load8 = 1'b1; load_bin8 = 8'h33; en8 = 1'b1; up8 = 1'b1;
        push4(4'h0, 4'h0, 1'b0);
        sb8.push_back('{bin: 8'h80, gray: 8'hC0, wrap: 1'b0});
        tick();
        e = sb4.pop_front();
        n_checks++;
        if ({bin4, gray4, wrap4} !== {e.bin[3:0], e.gray[3:0], e.wrap}) begin
            n_fail++;
            $display("FAIL reset4: got bin=%h gray=%h wrap=%b, want bin=%h gray=%h wrap=%b",
                     bin4, gray4, wrap4, e.bin[3:0], e.gray[3:0], e.wrap);
        end
        e = sb8.pop_front();
        n_checks++;
        if ({bin8, gray8, wrap8} !== {e.bin, e.gray, e.wrap}) begin
            n_fail++;
            $display("FAIL reset8: got bin=%h gray=%h wrap=%b, want bin=%h gray=%h wrap=%b",
                     bin8, gray8, wrap8, e.bin, e.gray, e.wrap);
        end
        rst8 = 1'b0; load8 = 1'b0; en8 = 1'b0;
    endtask

    task automatic test_count_up;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            drive4(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
            push4(4'((i + 1) % 16), g_tab[i], (i == 15));
            tick();
            e = sb4.pop_front();
            n_checks++;
            if ({bin4, gray4, wrap4} !== {e.bin[3:0], e.gray[3:0], e.wrap}) begin
                n_fail++;
                $display("FAIL count_up[%0d]: got bin=%h gray=%h wrap=%b, want bin=%h gray=%h wrap=%b",
                         i, bin4, gray4, wrap4, e.bin[3:0], e.gray[3:0], e.wrap);
            end
        end
    endtask

    task automatic test_count_down;
        exp_t e;
        push4(4'hF, 4'h8, 1'b1);
        push4(4'hE, 4'h9, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive4(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
            tick();
            e = sb4.pop_front();
            n_checks++;
            if ({bin4, gray4, wrap4} !== {e.bin[3:0], e.gray[3:0], e.wrap}) begin
                n_fail++;
                $display("FAIL count_down[%0d]: got bin=%h gray=%h wrap=%b, want bin=%h gray=%h wrap=%b",
                         i, bin4, gray4, wrap4, e.bin[3:0], e.gray[3:0], e.wrap);
            end
        end
    endtask

    task automatic test_load_priority;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive4(1'b0, 1'b1, 4'hA, 1'b1, 1'b1);
            else        drive4(1'b0, 1'b0, 4'h3, 1'b0, 1'b1);
            push4(4'hA, 4'hF, 1'b0);
            tick();
            e = sb4.pop_front();
            n_checks++;
            if ({bin4, gray4, wrap4} !== {e.bin[3:0], e.gray[3:0], e.wrap}) begin
                n_fail++;
                $display("FAIL load_hold[%0d]: got bin=%h gray=%h wrap=%b, want bin=%h gray=%h wrap=%b",
                         i, bin4, gray4, wrap4, e.bin[3:0], e.gray[3:0], e.wrap);
            end
        end
        // load at all-ones with en/up set must not raise wrap
        for (int i = 0; i < 2; i++) begin
            drive4(1'b0, 1'b1, 4'hF, 1'b1, 1'b1);
            push4(4'hF, 4'h8, 1'b0);
            tick();
            e = sb4.pop_front();
            n_checks++;
            if ({bin4, gray4, wrap4} !== {e.bin[3:0], e.gray[3:0], e.wrap}) begin
                n_fail++;
                $display("FAIL load_at_max[%0d]: got bin=%h gray=%h wrap=%b, want bin=%h gray=%h wrap=%b",
                         i, bin4, gray4, wrap4, e.bin[3:0], e.gray[3:0], e.wrap);
            end
        end
    endtask

    task automatic test_direction_flip;
        exp_t e;
        logic [4:0] seq [3] = '{5'b1_0000, 5'b0_1001, 5'b0_1000};
        push4(4'h5, 4'h7, 1'b0);
        push4(4'h6, 4'h5, 1'b0);
        push4(4'h5, 4'h7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive4(1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
            else        drive4(1'b0, 1'b0, 4'h0, 1'b1, (i == 1));
            tick();
            e = sb4.pop_front();
            n_checks++;
            if ({bin4, gray4, wrap4} !== {e.bin[3:0], e.gray[3:0], e.wrap}) begin
                n_fail++;
                $display("FAIL dir_flip[%0d]: got bin=%h gray=%h wrap=%b, want bin=%h gray=%h wrap=%b",
                         i, bin4, gray4, wrap4, e.bin[3:0], e.gray[3:0], e.wrap);
            end
        end
    endtask

    task automatic test_reset_mid_count;
        exp_t e;
        drive4(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        push4(4'h6, 4'h5, 1'b0);
        tick();
        e = sb4.pop_front();
        n_checks++;
        if ({bin4, gray4, wrap4} !== {e.bin[3:0], e.gray[3:0], e.wrap}) begin
            n_fail++;
            $display("FAIL pre_rst: got bin=%h gray=%h wrap=%b, want bin=%h gray=%h wrap=%b",
                     bin4, gray4, wrap4, e.bin[3:0], e.gray[3:0], e.wrap);
        end
        drive4(1'b1, 1'b1, 4'hC, 1'b1, 1'b0);
        push4(4'h0, 4'h0, 1'b0);
        tick();
        e = sb4.pop_front();
        n_checks++;
        if ({bin4, gray4, wrap4} !== {e.bin[3:0], e.gray[3:0], e.wrap}) begin
            n_fail++;
            $display("FAIL rst_mid_count: got bin=%h gray=%h wrap=%b, want bin=%h gray=%h wrap=%b",
                     bin4, gray4, wrap4, e.bin[3:0], e.gray[3:0], e.wrap);
        end
        drive4(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_random_w8;
        exp_t       e;
        logic [7:0] m_bin  = 8'h80;
        logic [7:0] g_prev = gray8;
        logic [7:0] g_exp;
        logic       w_exp;
        int         wraps  = 0;
        for (int i = 0; i < 600; i++) begin
            en8 = ($urandom_range(0, 7) != 0);
            up8 = (i < 300) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            load8 = 1'b0; rst8 = 1'b0; load_bin8 = 8'($urandom);
            w_exp = 1'b0;
            if (en8) begin
                w_exp = up8 ? (m_bin == 8'hFF) : (m_bin == 8'h00);
                m_bin = up8 ? m_bin + 8'd1 : m_bin - 8'd1;
            end
            g_exp = m_bin ^ {1'b0, m_bin[7:1]};
            sb8.push_back('{bin: m_bin, gray: g_exp, wrap: w_exp});
            if (w_exp) wraps++;
            tick();
            e = sb8.pop_front();
            n_checks++;
            if ({bin8, gray8, wrap8} !== {e.bin, e.gray, e.wrap}) begin
                n_fail++;
                $display("FAIL rand8[%0d]: got bin=%h gray=%h wrap=%b, want bin=%h gray=%h wrap=%b",
                         i, bin8, gray8, wrap8, e.bin, e.gray, e.wrap);
            end
            n_checks++;
            if (gray8 !== (bin8 ^ (bin8 >> 1))) begin
                n_fail++;
                $display("FAIL rand8_coherent[%0d]: gray=%h bin=%h, want gray=%h",
                         i, gray8, bin8, bin8 ^ (bin8 >> 1));
            end
            n_checks++;
            if ($countones(gray8 ^ g_prev) != (en8 ? 1 : 0)) begin
                n_fail++;
                $display("FAIL rand8_hamming[%0d]: distance=%0d, want %0d",
                         i, $countones(gray8 ^ g_prev), (en8 ? 1 : 0));
            end
            g_prev = gray8;
        end
        n_checks++;
        if (wraps < 1) begin
            n_fail++;
            $display("FAIL rand8_wrap_coverage: wraps=%0d, want >= 1", wraps);
        end
        en8 = 1'b0;
    endtask

    initial begin
        drive4(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        rst8 = 1'b1; en8 = 1'b0; up8 = 1'b0; load8 = 1'b0; load_bin8 = 8'h00;
        #1;
        test_reset();
        test_count_up();
        test_count_down();
        test_load_priority();
        test_direction_flip();
        test_reset_mid_count();
        test_random_w8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
